// File: rtl/issue_window_pkg.sv
// issue_window_pkg: shared types and helpers for the out-of-order issue pick window.
package issue_window_pkg;
    localparam int unsigned DEPTH_DEF = 4;

    typedef enum logic [2:0] {NONE, ALU, LOAD, STORE, CTRL_FLOW, CSR} fu_t;

    typedef struct packed {
        fu_t        fu;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [7:0] id;
    } sbe_t;

    typedef struct packed {
        sbe_t sbe;
        logic is_ctrl_flow;
        logic barrier;
    } window_entry_t;

    function automatic logic is_lsu(fu_t fu);
        return fu == LOAD || fu == STORE;
    endfunction

    function automatic logic is_barrier(fu_t fu, logic cf);
        return cf || fu == CTRL_FLOW || fu == CSR;
    endfunction
endpackage

// File: rtl/issue_window_hazard.sv
// issue_window_hazard: RAW/WAR/WAW/memory-order check of one younger entry against one older entry.
module issue_window_hazard
    import issue_window_pkg::*;
(
    input  fu_t        y_fu,
    input  logic [4:0] y_rs1,
    input  logic [4:0] y_rs2,
    input  logic [4:0] y_rd,
    input  fu_t        o_fu,
    input  logic [4:0] o_rs1,
    input  logic [4:0] o_rs2,
    input  logic [4:0] o_rd,
    output logic       hazard_o
);
    logic raw, war, waw, mem;

    always_comb begin
        raw = (o_fu != STORE) && (y_rs1 == o_rd || y_rs2 == o_rd);
        war = (y_rd == o_rs1) || (o_fu != LOAD && y_rd == o_rs2);
        waw = (o_fu != STORE) && (y_rd == o_rd);
        mem = is_lsu(y_fu) && is_lsu(o_fu);
        hazard_o = raw || war || waw || mem;
    end
endmodule

// File: rtl/issue_window_sched.sv
// issue_window_sched: age-ordered pick window between decode and issue, bypassing an LSU-blocked oldest entry.
// Optional ISSUE_WINDOW_STARVE_EN bounds how many times the oldest entry may be bypassed.
module issue_window_sched
    import issue_window_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
`ifdef ISSUE_WINDOW_STARVE_EN
    , parameter int unsigned STARVE_LIMIT = 4
`endif
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic lsu_ready_i,
    input  sbe_t issue_entry_i,
    input  logic issue_entry_valid_i,
    input  logic is_ctrl_flow_i,
    output logic issue_instr_ack_o,
    output sbe_t issue_entry_o,
    output logic issue_entry_valid_o,
    output logic is_ctrl_flow_o,
    input  logic issue_instr_ack_i
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);

    window_entry_t win_q [DEPTH];
    window_entry_t win_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] sel, wr_idx;
    logic [DEPTH-1:1] cand;
    logic [DEPTH-1:1][DEPTH-2:0] hz;
    logic pop, push, bar_in, starved;

    for (genvar i = 1; i < DEPTH; i++) begin : g_y
        for (genvar j = 0; j < DEPTH - 1; j++) begin : g_o
            if (j < i) begin : g_chk
                issue_window_hazard u_hz (
                    .y_fu    (win_q[i].sbe.fu),
                    .y_rs1   (win_q[i].sbe.rs1),
                    .y_rs2   (win_q[i].sbe.rs2),
                    .y_rd    (win_q[i].sbe.rd),
                    .o_fu    (win_q[j].sbe.fu),
                    .o_rs1   (win_q[j].sbe.rs1),
                    .o_rs2   (win_q[j].sbe.rs2),
                    .o_rd    (win_q[j].sbe.rd),
                    .hazard_o(hz[i][j])
                );
            end else begin : g_nil
                assign hz[i][j] = 1'b0;
            end
        end
    end

    // A barrier anywhere at or above slot i pins slot i behind it.
    always_comb begin
        logic bar_seen;
        bar_seen = win_q[0].barrier;
        cand = '0;
        for (int i = 1; i < DEPTH; i++) begin
            bar_seen = bar_seen || win_q[i].barrier;
            cand[i] = (i < int'(count_q)) && !bar_seen && !(|hz[i]);
        end
    end

    always_comb begin
        sel = '0;
        if (is_lsu(win_q[0].sbe.fu) && !lsu_ready_i && !starved)
            for (int i = DEPTH - 1; i >= 1; i--)
                if (cand[i] && !is_lsu(win_q[i].sbe.fu)) sel = IW'(i);
    end

    assign issue_entry_valid_o = count_q != '0;
    assign issue_entry_o = issue_entry_valid_o ? win_q[sel].sbe : '0;
    assign is_ctrl_flow_o = issue_entry_valid_o && win_q[sel].is_ctrl_flow;
    assign pop = issue_entry_valid_o && issue_instr_ack_i;
    assign bar_in = is_barrier(issue_entry_i.fu, is_ctrl_flow_i);
    // A held barrier sits alone in slot 0; nothing joins it until it leaves.
    assign issue_instr_ack_o = rst_ni && issue_entry_valid_i && !flush_i
        && (count_q < CW'(DEPTH) || pop)
        && (!bar_in || count_q == '0 || (count_q == CW'(1) && pop))
        && (!(issue_entry_valid_o && win_q[0].barrier) || pop);
    assign push = issue_instr_ack_o;
    assign wr_idx = IW'(count_q - CW'(pop));

    always_comb begin
        win_d = win_q;
        for (int i = 0; i < DEPTH - 1; i++)
            if (pop && i >= int'(sel)) win_d[i] = win_q[i + 1];
        if (push) win_d[wr_idx] = '{sbe: issue_entry_i, is_ctrl_flow: is_ctrl_flow_i, barrier: bar_in};
        count_d = flush_i ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
        end else begin
            count_q <= count_d;
            win_q <= win_d;
        end
    end

`ifdef ISSUE_WINDOW_STARVE_EN
    logic [2:0] starve_q, starve_d;

    assign starved = starve_q >= 3'(STARVE_LIMIT);
    assign starve_d = flush_i ? '0 : !pop ? starve_q : sel == '0 ? '0 : starve_q + 3'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) starve_q <= '0;
        else starve_q <= starve_d;
    end
`else
    assign starved = 1'b0;
`endif
endmodule

// File: tb/tb_issue_window_sched.sv
// tb_issue_window_sched: directed scenarios plus randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_issue_window_sched;
    import issue_window_pkg::*;

    localparam int D = 4;
    localparam int LIM = 4;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b1;
    logic flush_i = 1'b0;
    logic lsu_ready_i = 1'b0;
    logic issue_entry_valid_i = 1'b0;
    logic is_ctrl_flow_i = 1'b0;
    logic issue_instr_ack_i = 1'b0;
    sbe_t issue_entry_i = '0;
    sbe_t issue_entry_o;
    logic issue_instr_ack_o, issue_entry_valid_o, is_ctrl_flow_o;

    int checks = 0;
    int failures = 0;
    int starve = 0;
    int next_id = 1;

    typedef struct {
        sbe_t s;
        bit   cf;
    } ment_t;
    ment_t q[$];

    always #5 clk_i = ~clk_i;

    issue_window_sched dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .flush_i            (flush_i),
        .lsu_ready_i        (lsu_ready_i),
        .issue_entry_i      (issue_entry_i),
        .issue_entry_valid_i(issue_entry_valid_i),
        .is_ctrl_flow_i     (is_ctrl_flow_i),
        .issue_instr_ack_o  (issue_instr_ack_o),
        .issue_entry_o      (issue_entry_o),
        .issue_entry_valid_o(issue_entry_valid_o),
        .is_ctrl_flow_o     (is_ctrl_flow_o),
        .issue_instr_ack_i  (issue_instr_ack_i)
    );

    function automatic bit m_lsu(fu_t f);
        return f == LOAD || f == STORE;
    endfunction

    function automatic bit m_bar(fu_t f, bit cf);
        return cf || f == CTRL_FLOW || f == CSR;
    endfunction

    function automatic bit m_haz(sbe_t y, sbe_t o);
        bit h;
        h = 0;
        if (o.fu != STORE && (y.rs1 == o.rd || y.rs2 == o.rd)) h = 1;
        if (y.rd == o.rs1 || (o.fu != LOAD && y.rd == o.rs2)) h = 1;
        if (o.fu != STORE && y.rd == o.rd) h = 1;
        if (m_lsu(y.fu) && m_lsu(o.fu)) h = 1;
        return h;
    endfunction

    function automatic int m_sel();
        bit ok;
        if (q.size() == 0 || !m_lsu(q[0].s.fu) || lsu_ready_i) return 0;
`ifdef ISSUE_WINDOW_STARVE_EN
        if (starve >= LIM) return 0;
`endif
        for (int i = 1; i < q.size(); i++) begin
            ok = !m_lsu(q[i].s.fu);
            for (int j = 0; j <= i; j++) if (m_bar(q[j].s.fu, q[j].cf)) ok = 0;
            for (int j = 0; j < i; j++) if (m_haz(q[i].s, q[j].s)) ok = 0;
            if (ok) return i;
        end
        return 0;
    endfunction

    function automatic bit m_pop();
        return q.size() > 0 && issue_instr_ack_i;
    endfunction

    function automatic bit m_ack();
        bit p;
        int n;
        p = m_pop();
        n = q.size();
        if (!rst_ni || !issue_entry_valid_i || flush_i) return 0;
        if (n == D && !p) return 0;
        if (m_bar(issue_entry_i.fu, is_ctrl_flow_i) && !(n == 0 || (n == 1 && p))) return 0;
        if (n > 0 && m_bar(q[0].s.fu, q[0].cf) && !p) return 0;
        return 1;
    endfunction

    function automatic sbe_t m_entry();
        return q.size() == 0 ? sbe_t'(0) : q[m_sel()].s;
    endfunction

    function automatic bit m_cf();
        return q.size() > 0 && q[m_sel()].cf;
    endfunction

    task automatic drive(input bit v, input fu_t fu, input int rd, input int rs1, input int rs2,
                         input bit cf, input int id);
        issue_entry_valid_i = v;
        issue_entry_i = '{fu: fu, rs1: 5'(rs1), rs2: 5'(rs2), rd: 5'(rd), id: 8'(id)};
        is_ctrl_flow_i = cf;
    endtask

    task automatic tick();
        int s;
        bit p, a;
        ment_t e;
        s = m_sel();
        p = m_pop();
        a = m_ack();
        e.s = issue_entry_i;
        e.cf = is_ctrl_flow_i;
        @(posedge clk_i);
        if (!rst_ni || flush_i) begin
            q.delete();
            starve = 0;
        end else begin
            if (p) begin
                starve = s == 0 ? 0 : starve + 1;
                q.delete(s);
            end
            if (a) q.push_back(e);
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 0;
        flush_i = 0;
        lsu_ready_i = 0;
        issue_instr_ack_i = 0;
        drive(0, NONE, 0, 0, 0, 0, 0);
        q.delete();
        starve = 0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, ALU, 10 + k, 20 + k, 24 + k, 0, k + 1);
            tick();
        end
        drive(1, ALU, 15, 25, 26, 0, 9);
        #1;
        checks++; if (issue_entry_valid_o !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%0b exp=1", issue_entry_valid_o); end
        rst_ni = 0;
        #1;
        checks++; if (issue_entry_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid_low got=%0b exp=0", issue_entry_valid_o); end
        checks++; if (issue_instr_ack_o !== 1'b0) begin failures++; $display("FAIL rst_ack_low got=%0b exp=0", issue_instr_ack_o); end
        tick();
        rst_ni = 1;
        drive(0, NONE, 0, 0, 0, 0, 0);
        #1;
        checks++; if (issue_entry_valid_o !== 1'b0) begin failures++; $display("FAIL rst_after_valid got=%0b exp=0", issue_entry_valid_o); end
        checks++; if (issue_entry_o !== sbe_t'(0)) begin failures++; $display("FAIL rst_after_entry got=%h exp=0", issue_entry_o); end
        tick();
    endtask

    task automatic test_bypass();
        do_reset();
        drive(1, LOAD, 5, 10, 11, 0, 1);
        #1;
        checks++; if (issue_instr_ack_o !== 1'b1) begin failures++; $display("FAIL bp_ack_load got=%0b exp=1", issue_instr_ack_o); end
        checks++; if (issue_entry_valid_o !== 1'b0) begin failures++; $display("FAIL bp_no_bypass got=%0b exp=0", issue_entry_valid_o); end
        tick();
        drive(1, ALU, 6, 7, 8, 0, 2);
        #1;
        checks++; if (issue_entry_o.id !== 8'd1) begin failures++; $display("FAIL bp_load_alone got=%0d exp=1", issue_entry_o.id); end
        tick();
        drive(0, NONE, 0, 0, 0, 0, 0);
        issue_instr_ack_i = 1;
        #1;
        checks++; if (issue_entry_o.id !== 8'd2) begin failures++; $display("FAIL bp_add_first got=%0d exp=2", issue_entry_o.id); end
        tick();
        issue_instr_ack_i = 0;
        #1;
        checks++; if (issue_entry_o.id !== 8'd1 || issue_entry_valid_o !== 1'b1) begin failures++; $display("FAIL bp_load_wait got=%0d exp=1", issue_entry_o.id); end
        lsu_ready_i = 1;
        issue_instr_ack_i = 1;
        tick();
        issue_instr_ack_i = 0;
        #1;
        checks++; if (issue_entry_valid_o !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0b exp=0", issue_entry_valid_o); end
    endtask

    task automatic test_raw();
        do_reset();
        drive(1, LOAD, 5, 10, 11, 0, 1);
        tick();
        drive(1, ALU, 6, 5, 1, 0, 2);
        tick();
        drive(0, NONE, 0, 0, 0, 0, 0);
        #1;
        checks++; if (issue_entry_o.id !== 8'd1) begin failures++; $display("FAIL raw_load_offered got=%0d exp=1", issue_entry_o.id); end
        tick();
        #1;
        checks++; if (issue_entry_valid_o !== 1'b1 || issue_entry_o.id !== 8'd1) begin failures++; $display("FAIL raw_hold got=%0d exp=1", issue_entry_o.id); end
        lsu_ready_i = 1;
        issue_instr_ack_i = 1;
        tick();
        issue_instr_ack_i = 0;
        #1;
        checks++; if (issue_entry_o.id !== 8'd2) begin failures++; $display("FAIL raw_add_next got=%0d exp=2", issue_entry_o.id); end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < D; k++) begin
            drive(1, ALU, 10 + k, 1, 2, 0, k + 1);
            tick();
        end
        drive(1, ALU, 15, 1, 2, 0, 5);
        #1;
        checks++; if (issue_instr_ack_o !== 1'b0) begin failures++; $display("FAIL full_no_ack got=%0b exp=0", issue_instr_ack_o); end
        issue_instr_ack_i = 1;
        #1;
        checks++; if (issue_instr_ack_o !== 1'b1) begin failures++; $display("FAIL full_ack_with_pop got=%0b exp=1", issue_instr_ack_o); end
        tick();
        issue_instr_ack_i = 0;
        drive(1, ALU, 16, 1, 2, 0, 6);
        #1;
        checks++; if (issue_instr_ack_o !== 1'b0) begin failures++; $display("FAIL full_still_full got=%0b exp=0", issue_instr_ack_o); end
        checks++; if (issue_entry_o.id !== 8'd2) begin failures++; $display("FAIL full_head_after_pop got=%0d exp=2", issue_entry_o.id); end
    endtask

    task automatic test_barrier();
        do_reset();
        drive(1, ALU, 10, 1, 2, 0, 1);
        tick();
        drive(1, ALU, 11, 1, 2, 0, 2);
        tick();
        drive(1, CTRL_FLOW, 0, 3, 4, 1, 3);
        #1;
        checks++; if (issue_instr_ack_o !== 1'b0) begin failures++; $display("FAIL bar_blocked got=%0b exp=0", issue_instr_ack_o); end
        issue_instr_ack_i = 1;
        #1;
        checks++; if (issue_instr_ack_o !== 1'b0) begin failures++; $display("FAIL bar_blocked_pop got=%0b exp=0", issue_instr_ack_o); end
        tick();
        #1;
        checks++; if (issue_instr_ack_o !== 1'b1) begin failures++; $display("FAIL bar_accept_last got=%0b exp=1", issue_instr_ack_o); end
        tick();
        issue_instr_ack_i = 0;
        drive(1, ALU, 7, 8, 9, 0, 4);
        #1;
        checks++; if (issue_entry_o.id !== 8'd3 || is_ctrl_flow_o !== 1'b1) begin failures++; $display("FAIL bar_beq_alone got=%0d/%0b exp=3/1", issue_entry_o.id, is_ctrl_flow_o); end
        checks++; if (issue_instr_ack_o !== 1'b0) begin failures++; $display("FAIL bar_behind_beq got=%0b exp=0", issue_instr_ack_o); end
        tick();
        issue_instr_ack_i = 1;
        #1;
        checks++; if (issue_instr_ack_o !== 1'b1) begin failures++; $display("FAIL bar_accept_on_pop got=%0b exp=1", issue_instr_ack_o); end
        tick();
        issue_instr_ack_i = 0;
        drive(0, NONE, 0, 0, 0, 0, 0);
        #1;
        checks++; if (issue_entry_o.id !== 8'd4 || is_ctrl_flow_o !== 1'b0) begin failures++; $display("FAIL bar_next got=%0d/%0b exp=4/0", issue_entry_o.id, is_ctrl_flow_o); end
    endtask

    task automatic test_starve();
        do_reset();
        drive(1, STORE, 31, 1, 2, 0, 1);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1, ALU, 10 + k, 20, 21, 0, k + 2);
            issue_instr_ack_i = q.size() > 0 && !m_lsu(q[m_sel()].s.fu);
            #1;
            checks++; if (issue_entry_o !== m_entry()) begin failures++; $display("FAIL starve_entry got=%h exp=%h", issue_entry_o, m_entry()); end
            tick();
        end
        issue_instr_ack_i = 0;
        #1;
`ifdef ISSUE_WINDOW_STARVE_EN
        checks++; if (issue_entry_o.id !== 8'd1) begin failures++; $display("FAIL starve_store_forced got=%0d exp=1", issue_entry_o.id); end
`else
        checks++; if (issue_entry_o.fu !== ALU) begin failures++; $display("FAIL starve_bypass got=%0d exp=%0d", issue_entry_o.fu, ALU); end
`endif
        flush_i = 1;
        #1;
        checks++; if (issue_instr_ack_o !== 1'b0) begin failures++; $display("FAIL flush_ack got=%0b exp=0", issue_instr_ack_o); end
        checks++; if (issue_entry_valid_o !== 1'b1) begin failures++; $display("FAIL flush_pre_valid got=%0b exp=1", issue_entry_valid_o); end
        tick();
        flush_i = 0;
        drive(0, NONE, 0, 0, 0, 0, 0);
        #1;
        checks++; if (issue_entry_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", issue_entry_valid_o); end
    endtask

    task automatic test_random();
        fu_t f;
        int r;
        sbe_t e_entry;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 9));
            f = r < 4 ? ALU : r < 6 ? LOAD : r < 8 ? STORE : r == 8 ? CSR : CTRL_FLOW;
            drive($urandom_range(0, 3) != 0, f, int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                  int'($urandom_range(0, 11)), f == CTRL_FLOW || $urandom_range(0, 19) == 0, next_id);
            next_id++;
            lsu_ready_i = $urandom_range(0, 2) == 0;
            issue_instr_ack_i = $urandom_range(0, 1) == 1;
            flush_i = $urandom_range(0, 49) == 0;
            #1;
            e_entry = m_entry();
            checks++; if (issue_instr_ack_o !== m_ack()) begin failures++; $display("FAIL rnd_ack cyc=%0d got=%0b exp=%0b", k, issue_instr_ack_o, m_ack()); end
            checks++; if (issue_entry_valid_o !== (q.size() > 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", k, issue_entry_valid_o, q.size() > 0); end
            checks++; if (issue_entry_o !== e_entry) begin failures++; $display("FAIL rnd_entry cyc=%0d got=%h exp=%h", k, issue_entry_o, e_entry); end
            checks++; if (is_ctrl_flow_o !== m_cf()) begin failures++; $display("FAIL rnd_cf cyc=%0d got=%0b exp=%0b", k, is_ctrl_flow_o, m_cf()); end
            tick();
        end
        flush_i = 0;
    endtask

    initial begin
        #1;
        test_reset();
        test_bypass();
        test_raw();
        test_full();
        test_barrier();
        test_starve();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
